// File: rtl/branch_spec_tracker.sv
// Speculative branch tracker: in-order FIFO of predicted branches with mispredict flush/recovery FSM.
// Optional macro BR_TRACK_PERF_EN adds saturating resolve/mispredict performance counters.
module branch_spec_tracker #(
    parameter int DEPTH          = 4,
    parameter int PC_WIDTH       = 16,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       alloc_v_i,
    input  logic                       alloc_taken_i,
    input  logic [PC_WIDTH-1:0]        alloc_alt_pc_i,
    output logic                       alloc_ready_o,
    input  logic                       resolve_v_i,
    input  logic                       resolve_taken_i,
    output logic                       flush_o,
    output logic                       redirect_v_o,
    output logic [PC_WIDTH-1:0]        redirect_pc_o,
    output logic                       fetch_stall_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef BR_TRACK_PERF_EN
    ,
    output logic [15:0]                perf_resolved_o,
    output logic [15:0]                perf_mispredict_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RC_W  = $clog2(RECOVER_CYCLES + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_FLUSH   = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    logic [1:0]          state;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic [RC_W-1:0]     rec_cnt;
    logic [PC_WIDTH-1:0] redirect_pc;

    logic                mem_taken [DEPTH];
    logic [PC_WIDTH-1:0] mem_pc    [DEPTH];

    logic resolve_ok;
    logic mispredict;
    logic pop;
    logic push;

    // Readiness depends only on registered occupancy; a same-cycle pop never frees a slot.
    assign alloc_ready_o = (state == ST_RUN) && (count != FULL_CNT);
    assign resolve_ok    = resolve_v_i && (count != '0) && (state == ST_RUN);
    assign mispredict    = resolve_ok && (resolve_taken_i != mem_taken[head]);
    assign pop           = resolve_ok && !mispredict;
    assign push          = alloc_v_i && alloc_ready_o && !mispredict;

    assign flush_o       = (state == ST_FLUSH);
    assign redirect_v_o  = (state == ST_FLUSH);
    assign redirect_pc_o = redirect_pc;
    assign fetch_stall_o = (state != ST_RUN) || (count == FULL_CNT);
    assign count_o       = count;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_taken[tail] <= alloc_taken_i;
            mem_pc[tail]    <= alloc_alt_pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_RUN;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            rec_cnt     <= '0;
            redirect_pc <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mispredict) begin
                        state       <= ST_FLUSH;
                        redirect_pc <= mem_pc[head];
                        head        <= '0;
                        tail        <= '0;
                        count       <= '0;
                    end else begin
                        if (push) tail <= tail + PTR_W'(1);
                        if (pop)  head <= head + PTR_W'(1);
                        if (push && !pop)      count <= count + CNT_W'(1);
                        else if (pop && !push) count <= count - CNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    state   <= ST_RECOVER;
                    rec_cnt <= RC_W'(RECOVER_CYCLES);
                end
                ST_RECOVER: begin
                    if (rec_cnt <= RC_W'(1)) begin
                        state   <= ST_RUN;
                        rec_cnt <= '0;
                    end else begin
                        rec_cnt <= rec_cnt - RC_W'(1);
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef BR_TRACK_PERF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_resolved_o   <= '0;
            perf_mispredict_o <= '0;
        end else begin
            if (resolve_ok && (perf_resolved_o != '1))
                perf_resolved_o <= perf_resolved_o + 16'd1;
            if (mispredict && (perf_mispredict_o != '1))
                perf_mispredict_o <= perf_mispredict_o + 16'd1;
        end
    end
`endif

endmodule

// File: doc/branch_spec_tracker.md
BRANCH_SPEC_TRACKER -- requirements
Module: branch_spec_tracker

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the maximum outstanding speculative branches (power of two, >=2).
REQ-002 Parameter PC_WIDTH, default 16, SHALL set the width of the recovery PC.
REQ-003 Parameter RECOVER_CYCLES, default 2, SHALL set the post-flush fetch-stall length (>=1).
REQ-004 clk_i  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n_i  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 alloc_v_i  input  1  SHALL mark a new speculative branch from the front end.
REQ-007 alloc_taken_i  input  1  SHALL give the predicted direction (1 = taken).
REQ-008 alloc_alt_pc_i  input  PC_WIDTH  SHALL give the PC of the not-predicted path.
REQ-009 alloc_ready_o  output  1  SHALL indicate the tracker accepts an allocation this cycle.
REQ-010 resolve_v_i  input  1  SHALL mark in-order resolution of the oldest tracked branch.
REQ-011 resolve_taken_i  input  1  SHALL give the actual direction of that branch.
REQ-012 flush_o  output  1  SHALL pulse one cycle to kill all younger instructions.
REQ-013 redirect_v_o  output  1  SHALL qualify redirect_pc_o; asserted coincident with flush_o.
REQ-014 redirect_pc_o  output  PC_WIDTH  SHALL carry the recovery PC.
REQ-015 fetch_stall_o  output  1  SHALL hold fetch while recovering or full.
REQ-016 count_o  output  clog2(DEPTH+1)  SHALL report the number of occupied entries.

Function
REQ-017 Storage SHALL be a circular FIFO of DEPTH entries {taken, alt_pc}, head/tail pointers wrapping modulo DEPTH.
REQ-018 FSM states SHALL be RUN, FLUSH, RECOVER; reset state RUN.
REQ-019 alloc_ready_o SHALL equal (state==RUN && count<DEPTH), derived from registered state only; a same-cycle resolve does not free space.
REQ-020 Allocation SHALL occur when alloc_v_i && alloc_ready_o; entry written at tail, tail advances.
REQ-021 resolve_v_i SHALL be ignored when count==0 or state!=RUN.
REQ-022 Correct resolve (resolve_taken_i == head.taken) SHALL pop head; no other effect.
REQ-023 Mispredict SHALL transition RUN->FLUSH at the next edge, register redirect_pc_o = head.alt_pc, clear all entries (count=0, head=tail=0).
REQ-024 An allocation in the same cycle as a mispredict SHALL be discarded.
REQ-025 Simultaneous allocation and correct resolve SHALL leave count unchanged, both pointers advancing.
REQ-026 In FLUSH, flush_o and redirect_v_o SHALL be 1 for exactly one cycle; next state RECOVER.
REQ-027 RECOVER SHALL last exactly RECOVER_CYCLES cycles via a down-counter, then return to RUN.
REQ-028 fetch_stall_o SHALL equal (state!=RUN || count==DEPTH).
REQ-029 Mispredict-to-flush_o latency SHALL be one cycle; flush_o to alloc_ready_o re-assertion SHALL be RECOVER_CYCLES+1 cycles.

Reset
REQ-030 Reset assertion SHALL immediately force state RUN, count/pointers 0, recover counter 0, flush_o=0, redirect_v_o=0, redirect_pc_o=0, fetch_stall_o=0, alloc_ready_o=1.
REQ-031 Reset mid-FLUSH or mid-RECOVER SHALL abort recovery with no further flush pulse.

Configuration
REQ-032 Macro BR_TRACK_PERF_EN defined SHALL add outputs perf_resolved_o and perf_mispredict_o (16-bit each, saturating at 0xFFFF, reset 0) counting accepted resolves and mispredicts.
REQ-033 Without BR_TRACK_PERF_EN these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-034 Reset, allocate 4 branches back-to-back -> count_o=4, alloc_ready_o=0, fetch_stall_o=1; fifth alloc_v_i dropped.
REQ-035 Full, alloc_v_i and correct resolve same cycle -> alloc not accepted, count_o=3 next cycle.
REQ-036 Alloc taken=1 alt_pc=0x1234, resolve_taken_i=0 -> next cycle flush_o=1, redirect_pc_o=0x1234, count_o=0; fetch_stall_o high 3 cycles total, then alloc_ready_o=1.
REQ-037 Count=2, alloc plus correct resolve same cycle -> count_o stays 2; 8 such cycles exercise pointer wrap with FIFO order preserved.
REQ-038 Assert rst_n_i low during RECOVER -> outputs at reset values immediately, no flush pulse after release.
REQ-039 BR_TRACK_PERF_EN: 3 resolves with 1 mispredict -> perf_resolved_o=3, perf_mispredict_o=1.
